// File: rtl/mdu_iterative_pkg.sv
// Shared encodings for the iterative multiply/divide unit: funct3 ops, FSM states, latencies.
// Also used by the decoder so op encodings stay in one place.
package mdu_iterative_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   function automatic int mdu_mul_calc_cycles(input int w, input int step);
      return w / step;
   endfunction

   function automatic int mdu_div_calc_cycles(input int w);
      return w;
   endfunction

   function automatic int mdu_mul_latency(input int w, input int step);
      return w / step + 2;
   endfunction

   function automatic int mdu_div_latency(input int w);
      return w + 2;
   endfunction

   // rs1 is signed for MUL, MULH, MULHSU, DIV, REM
   function automatic logic op_s1_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_s2_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division iteration on magnitudes:
// shift {rem, quo} left, trial-subtract the divisor, keep or restore.
module mdu_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_rem,
   input  logic [W-1:0] i_quo,
   input  logic [W-1:0] i_div,
   output logic [W-1:0] o_rem,
   output logic [W-1:0] o_quo
);

   logic [W:0]   w_shift;
   logic [W-1:0] w_sub;
   logic         w_borrow;

   assign w_shift  = {i_rem, i_quo[W-1]};
   assign w_borrow = w_shift < {1'b0, i_div};
   // when the subtract succeeds the true difference is below the divisor, so W bits suffice
   assign w_sub    = w_shift[W-1:0] - i_div;
   assign o_rem    = w_borrow ? w_shift[W-1:0] : w_sub;
   assign o_quo    = {i_quo[W-2:0], ~w_borrow};

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready in and out.
// Optional MDU_DIV_REUSE_EN: reuse the last division's quotient/remainder for identical operands.
module mdu_iterative
   import mdu_iterative_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MUL_STEP   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [DATA_WIDTH-1:0] in_s1,
   input  logic [DATA_WIDTH-1:0] in_s2,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy
);

   localparam int W       = DATA_WIDTH;
   localparam int S       = MUL_STEP;
   localparam int CW      = $clog2(W);
   localparam int MUL_CYC = mdu_mul_calc_cycles(W, S);
   localparam int DIV_CYC = mdu_div_calc_cycles(W);
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   mdu_state_e     r_state;
   logic [2:0]     r_op;
   logic           r_neg_q;
   logic           r_neg_r;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [2*W-1:0] r_prod;
   logic [CW-1:0]  r_cnt;
   logic           r_out_valid;
   logic [W-1:0]   r_out_data;

   logic           w_s1_sgn, w_s2_sgn, w_neg1, w_neg2;
   logic [W-1:0]   w_mag1, w_mag2;
   logic           w_is_div, w_is_rem, w_div0, w_ovf;
   logic [W-1:0]   w_special_data;
   logic           w_hit;
   logic [W-1:0]   w_hit_data;
   logic [W+S-1:0] w_part, w_sum;
   logic [2*W-1:0] w_mul_next, w_prod_fix;
   logic [W-1:0]   w_div_rem, w_div_quo;
   logic [W-1:0]   w_quo_fix, w_rem_fix, w_result;

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

   assign w_s1_sgn = op_s1_signed(in_op);
   assign w_s2_sgn = op_s2_signed(in_op);
   assign w_neg1   = w_s1_sgn & in_s1[W-1];
   assign w_neg2   = w_s2_sgn & in_s2[W-1];
   assign w_mag1   = w_neg1 ? -in_s1 : in_s1;
   assign w_mag2   = w_neg2 ? -in_s2 : in_s2;
   assign w_is_div = in_op[2];
   assign w_is_rem = in_op[1];
   assign w_div0   = (in_s2 == '0);
   assign w_ovf    = !in_op[0] && (in_s1 == MIN_VAL) && (in_s2 == '1);

   always_comb begin
      w_special_data = '0;
      if (w_div0)
         w_special_data = w_is_rem ? in_s1 : '1;
      else
         w_special_data = w_is_rem ? '0 : MIN_VAL;
   end

   // Multiplier low half holds the remaining multiplier bits; each cycle retires S of them
   always_comb begin
      w_part = '0;
      for (int i = 0; i < S; i++)
         if (r_prod[i]) w_part = w_part + ({{S{1'b0}}, r_a} << i);
   end
   assign w_sum      = {{S{1'b0}}, r_prod[2*W-1:W]} + w_part;
   assign w_mul_next = {w_sum, r_prod[W-1:S]};

   mdu_div_step #(.W(W)) u_div_step (
      .i_rem (r_prod[2*W-1:W]),
      .i_quo (r_prod[W-1:0]),
      .i_div (r_b),
      .o_rem (w_div_rem),
      .o_quo (w_div_quo)
   );

   assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
   assign w_quo_fix  = r_neg_q ? -r_prod[W-1:0] : r_prod[W-1:0];
   assign w_rem_fix  = r_neg_r ? -r_prod[2*W-1:W] : r_prod[2*W-1:W];

   always_comb begin
      case (r_op)
         OP_MUL:                     w_result = w_prod_fix[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_prod_fix[2*W-1:W];
         OP_DIV, OP_DIVU:            w_result = w_quo_fix;
         default:                    w_result = w_rem_fix;
      endcase
   end

`ifdef MDU_DIV_REUSE_EN
   logic         r_rv_valid, r_rv_sgn;
   logic [W-1:0] r_rv_s1, r_rv_s2, r_rv_quo, r_rv_rem, r_s1, r_s2;

   assign w_hit      = r_rv_valid && w_is_div && (r_rv_s1 == in_s1) &&
                       (r_rv_s2 == in_s2) && (r_rv_sgn == !in_op[0]);
   assign w_hit_data = w_is_rem ? r_rv_rem : r_rv_quo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rv_valid <= 1'b0;
         r_rv_sgn   <= 1'b0;
         r_rv_s1    <= '0;
         r_rv_s2    <= '0;
         r_rv_quo   <= '0;
         r_rv_rem   <= '0;
         r_s1       <= '0;
         r_s2       <= '0;
      end else if (flush) begin
         r_rv_valid <= 1'b0;
      end else if (r_state == ST_IDLE && in_valid) begin
         r_s1 <= in_s1;
         r_s2 <= in_s2;
         if (!w_is_div) r_rv_valid <= 1'b0;
      end else if (r_state == ST_FIX && r_op[2]) begin
         r_rv_valid <= 1'b1;
         r_rv_sgn   <= !r_op[0];
         r_rv_s1    <= r_s1;
         r_rv_s2    <= r_s2;
         r_rv_quo   <= w_quo_fix;
         r_rv_rem   <= w_rem_fix;
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_hit_data = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_op        <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_prod      <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && !flush) begin
                  r_op    <= in_op;
                  r_neg_q <= w_neg1 ^ w_neg2;
                  r_neg_r <= w_neg1;
                  r_a     <= w_mag1;
                  r_b     <= w_mag2;
                  r_prod  <= {{W{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                  if (w_is_div && (w_div0 || w_ovf)) begin
                     r_out_data  <= w_special_data;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else if (w_hit) begin
                     r_out_data  <= w_hit_data;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_cnt   <= w_is_div ? CW'(DIV_CYC - 1) : CW'(MUL_CYC - 1);
                     r_state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (flush) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_prod <= r_op[2] ? {w_div_rem, w_div_quo} : w_mul_next;
                  if (r_cnt == '0) r_state <= ST_FIX;
                  else             r_cnt   <= r_cnt - 1'b1;
               end
            end
            ST_FIX: begin
               if (flush) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_out_data  <= w_result;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               // flush discards the result even if the consumer is taking it this cycle
               if (flush || out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
